// File: rtl/csr_ext_arbiter.sv
// Two-port arbiter/sequencer for the external CSR bus: round-robin grant, atomic
// read-then-optional-write sequence with CSRRW/S/C resolution and per-phase timeout.
module csr_ext_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_m0_req,
   input  logic        i_m0_wr,
   input  logic        i_m0_set,
   input  logic        i_m0_clr,
   input  logic [11:0] i_m0_addr,
   input  logic [31:0] i_m0_wr_data,
   output logic        o_m0_ack,
   output logic        o_m0_err,
   input  logic        i_m1_req,
   input  logic        i_m1_wr,
   input  logic        i_m1_set,
   input  logic        i_m1_clr,
   input  logic [11:0] i_m1_addr,
   input  logic [31:0] i_m1_wr_data,
   output logic        o_m1_ack,
   output logic        o_m1_err,
   output logic [31:0] o_rd_data,
   output logic [11:0] o_ext_addr,
   output logic [31:0] o_ext_wr_data,
   output logic        o_ext_rd,
   output logic        o_ext_wr,
   input  logic [31:0] i_ext_rd_data,
   input  logic        i_ext_ready,
   output logic        o_busy
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state;
   logic        last_grant;
   logic        grant;
   logic        cmd_wr;
   logic        cmd_set;
   logic        cmd_clr;
   logic [31:0] operand;
   logic [31:0] old_q;
   logic [7:0]  cnt;

   logic        pick;
   logic        to_hit;
   logic [31:0] wdata_next;

   always_comb begin
      pick = 1'b0;
      if (i_m0_req && i_m1_req) pick = ~last_grant;
      else                      pick = ~i_m0_req;
      to_hit = (cnt == 8'(TIMEOUT - 1));
      // Write data is built from the bus value being captured this cycle.
      if (cmd_wr)       wdata_next = operand;
      else if (cmd_set) wdata_next = i_ext_rd_data | operand;
      else              wdata_next = i_ext_rd_data & ~operand;
   end

   assign o_rd_data = old_q;
   assign o_busy    = (state != IDLE);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         grant         <= 1'b0;
         cmd_wr        <= 1'b0;
         cmd_set       <= 1'b0;
         cmd_clr       <= 1'b0;
         operand       <= '0;
         old_q         <= '0;
         cnt           <= '0;
         o_ext_addr    <= '0;
         o_ext_wr_data <= '0;
         o_ext_rd      <= 1'b0;
         o_ext_wr      <= 1'b0;
         o_m0_ack      <= 1'b0;
         o_m0_err      <= 1'b0;
         o_m1_ack      <= 1'b0;
         o_m1_err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_m0_req || i_m1_req) begin
                  grant      <= pick;
                  last_grant <= pick;
                  cmd_wr     <= pick ? i_m1_wr      : i_m0_wr;
                  cmd_set    <= pick ? i_m1_set     : i_m0_set;
                  cmd_clr    <= pick ? i_m1_clr     : i_m0_clr;
                  operand    <= pick ? i_m1_wr_data : i_m0_wr_data;
                  o_ext_addr <= pick ? i_m1_addr    : i_m0_addr;
                  cnt        <= '0;
                  o_ext_rd   <= 1'b1;
                  state      <= READ;
               end
            end
            READ: begin
               if (i_ext_ready) begin
                  old_q    <= i_ext_rd_data;
                  o_ext_rd <= 1'b0;
                  cnt      <= '0;
                  if (cmd_wr || cmd_set || cmd_clr) begin
                     o_ext_wr_data <= wdata_next;
                     o_ext_wr      <= 1'b1;
                     state         <= WRITE;
                  end else begin
                     o_m0_ack <= ~grant;
                     o_m1_ack <= grant;
                     state    <= RESP;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
                  if (to_hit) begin
                     old_q    <= '0;
                     o_ext_rd <= 1'b0;
                     o_m0_ack <= ~grant;
                     o_m1_ack <= grant;
                     o_m0_err <= ~grant;
                     o_m1_err <= grant;
                     state    <= RESP;
                  end
               end
            end
            WRITE: begin
               if (i_ext_ready || to_hit) begin
                  o_ext_wr <= 1'b0;
                  o_m0_ack <= ~grant;
                  o_m1_ack <= grant;
                  o_m0_err <= ~grant & ~i_ext_ready;
                  o_m1_err <= grant & ~i_ext_ready;
                  state    <= RESP;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RESP: begin
               o_m0_ack <= 1'b0;
               o_m1_ack <= 1'b0;
               o_m0_err <= 1'b0;
               o_m1_err <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_ext_arbiter.sv
// Bench for csr_ext_arbiter: transaction-level expectation queue checked every cycle,
// plus directed scenarios with literal expectations.
module tb_csr_ext_arbiter;
   localparam int unsigned TO = 16;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_m0_req = 1'b0, i_m0_wr = 1'b0, i_m0_set = 1'b0, i_m0_clr = 1'b0;
   logic [11:0] i_m0_addr = '0;
   logic [31:0] i_m0_wr_data = '0;
   logic        i_m1_req = 1'b0, i_m1_wr = 1'b0, i_m1_set = 1'b0, i_m1_clr = 1'b0;
   logic [11:0] i_m1_addr = '0;
   logic [31:0] i_m1_wr_data = '0;
   logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
   logic [31:0] o_rd_data;
   logic [11:0] o_ext_addr;
   logic [31:0] o_ext_wr_data;
   logic        o_ext_rd, o_ext_wr, o_busy;
   logic [31:0] i_ext_rd_data = '0;
   logic        i_ext_ready = 1'b0;

   csr_ext_arbiter #(.TIMEOUT(TO)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_m0_req(i_m0_req), .i_m0_wr(i_m0_wr), .i_m0_set(i_m0_set), .i_m0_clr(i_m0_clr),
      .i_m0_addr(i_m0_addr), .i_m0_wr_data(i_m0_wr_data), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
      .i_m1_req(i_m1_req), .i_m1_wr(i_m1_wr), .i_m1_set(i_m1_set), .i_m1_clr(i_m1_clr),
      .i_m1_addr(i_m1_addr), .i_m1_wr_data(i_m1_wr_data), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
      .o_rd_data(o_rd_data), .o_ext_addr(o_ext_addr), .o_ext_wr_data(o_ext_wr_data),
      .o_ext_rd(o_ext_rd), .o_ext_wr(o_ext_wr), .i_ext_rd_data(i_ext_rd_data),
      .i_ext_ready(i_ext_ready), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Slave: ready after lat_* strobe cycles (>= TO means never); ready idles high.
   int          lat_rd = 0, lat_wr = 0;
   logic [31:0] slave_data = '0;
   int          pcnt = 0, prev_kind = 0;

   always @(negedge i_clk) begin : slave_p
      int kind;
      kind = o_ext_rd ? 1 : (o_ext_wr ? 2 : 0);
      if (kind != 0 && kind == prev_kind) pcnt++;
      else pcnt = 0;
      prev_kind = kind;
      i_ext_rd_data = slave_data;
      if (kind == 0)      i_ext_ready = 1'b1;
      else if (kind == 1) i_ext_ready = (pcnt == lat_rd);
      else                i_ext_ready = (pcnt == lat_wr);
   end

   // Expected per-cycle outputs; one entry per cycle after a grant.
   typedef struct packed {
      logic        rd, wr, ack0, ack1, err, busy;
      logic [11:0] addr;
      logic [31:0] wdata, rdata;
   } exp_t;

   exp_t        q[$];
   logic [11:0] m_addr  = '0;
   logic [31:0] m_wdata = '0;
   int          m_last  = 1;

   task automatic model_grant();
      int p, rlen, wlen;
      logic w, s, c, rto, wto, has_w;
      logic [11:0] a;
      logic [31:0] op, old, nw;
      exp_t e;
      p = (i_m0_req && i_m1_req) ? 1 - m_last : (i_m0_req ? 0 : 1);
      m_last = p;
      w  = p ? i_m1_wr : i_m0_wr;
      s  = p ? i_m1_set : i_m0_set;
      c  = p ? i_m1_clr : i_m0_clr;
      a  = p ? i_m1_addr : i_m0_addr;
      op = p ? i_m1_wr_data : i_m0_wr_data;
      rto  = (lat_rd >= int'(TO));
      rlen = rto ? int'(TO) : lat_rd + 1;
      old  = rto ? 32'h0 : slave_data;
      has_w = !rto && (w || s || c);
      nw   = w ? op : (s ? (old | op) : (old & ~op));
      wto  = (lat_wr >= int'(TO));
      wlen = wto ? int'(TO) : lat_wr + 1;
      m_addr = a;
      for (int i = 0; i < rlen; i++) begin
         e = '0; e.rd = 1'b1; e.busy = 1'b1; e.addr = a; e.wdata = m_wdata;
         q.push_back(e);
      end
      if (has_w) begin
         m_wdata = nw;
         for (int i = 0; i < wlen; i++) begin
            e = '0; e.wr = 1'b1; e.busy = 1'b1; e.addr = a; e.wdata = nw;
            q.push_back(e);
         end
      end
      e = '0; e.busy = 1'b1; e.addr = a; e.wdata = m_wdata;
      e.ack0 = (p == 0); e.ack1 = (p == 1);
      e.err = rto || (has_w && wto); e.rdata = old;
      q.push_back(e);
      e = '0; e.addr = a; e.wdata = m_wdata;
      q.push_back(e);
   endtask

   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         q.delete(); m_addr = '0; m_wdata = '0; m_last = 1;
      end else if (q.size() == 0 && (i_m0_req || i_m1_req)) begin
         model_grant();
      end
   end

   always @(negedge i_clk) begin : cmp_p
      exp_t e, a;
      if (!i_rst) begin
         if (q.size() > 0) e = q.pop_front();
         else begin e = '0; e.addr = m_addr; e.wdata = m_wdata; end
         a = '0;
         a.rd = o_ext_rd; a.wr = o_ext_wr; a.ack0 = o_m0_ack; a.ack1 = o_m1_ack; a.busy = o_busy;
         a.addr = o_ext_addr; a.wdata = o_ext_wr_data;
         a.err   = o_m0_ack ? o_m0_err : (o_m1_ack ? o_m1_err : 1'b0);
         a.rdata = (o_m0_ack || o_m1_ack) ? o_rd_data : 32'h0;
         chk("cycle", {46'h0, a}, {46'h0, e});
      end
   end

   int          r_cyc, r_nrd, r_nwr;
   logic [31:0] r_rd, r_wd;
   logic        r_err;

   task automatic run_txn(input int port, input logic w, input logic s, input logic c,
                          input logic [11:0] a, input logic [31:0] op);
      logic got;
      got = 1'b0; r_cyc = 0; r_nrd = 0; r_nwr = 0; r_rd = '0; r_wd = '0; r_err = 1'b0;
      @(negedge i_clk);
      if (port == 0) begin
         i_m0_req = 1'b1; i_m0_wr = w; i_m0_set = s; i_m0_clr = c; i_m0_addr = a; i_m0_wr_data = op;
      end else begin
         i_m1_req = 1'b1; i_m1_wr = w; i_m1_set = s; i_m1_clr = c; i_m1_addr = a; i_m1_wr_data = op;
      end
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge i_clk);
         r_cyc++;
         if (o_ext_rd) r_nrd++;
         if (o_ext_wr) begin r_nwr++; r_wd = o_ext_wr_data; end
         if (port == 0 ? o_m0_ack : o_m1_ack) begin
            got = 1'b1; r_rd = o_rd_data; r_err = (port == 0) ? o_m0_err : o_m1_err;
         end
      end
      i_m0_req = 1'b0; i_m1_req = 1'b0;
      chk("ack_wait", {127'h0, got}, 128'h1);
   endtask

   int order[4];
   int nack;

   task automatic run_both(input int n);
      nack = 0;
      i_m0_wr = 0; i_m0_set = 0; i_m0_clr = 0; i_m0_addr = 12'h010; i_m0_wr_data = '0;
      i_m1_wr = 0; i_m1_set = 0; i_m1_clr = 0; i_m1_addr = 12'h020; i_m1_wr_data = '0;
      i_m0_req = 1'b1; i_m1_req = 1'b1;
      for (int i = 0; i < 400 && nack < n; i++) begin
         @(negedge i_clk);
         if (o_m0_ack)      begin order[nack] = 0; nack++; end
         else if (o_m1_ack) begin order[nack] = 1; nack++; end
      end
      i_m0_req = 1'b0; i_m1_req = 1'b0;
      chk("both_ack_count", nack, n);
   endtask

   task automatic apply_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      chk("reset_outputs",
          {o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_ext_rd, o_ext_wr, o_busy, o_ext_addr, o_ext_wr_data, o_rd_data},
          '0);
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1);
   end

   initial begin : stim
      logic got;
      apply_reset();

      slave_data = 32'h1234_5678; lat_rd = 0; lat_wr = 0;
      run_txn(0, 0, 0, 0, 12'h200, 32'h0);
      chk("rd_cycles", r_cyc, 2);
      chk("rd_nrd", r_nrd, 1);
      chk("rd_nwr", r_nwr, 0);
      chk("rd_data", r_rd, 32'h1234_5678);
      chk("rd_err", {127'h0, r_err}, 128'h0);

      slave_data = 32'h0000_000F;
      run_txn(1, 0, 1, 0, 12'h300, 32'h0000_00F0);
      chk("set_wdata", r_wd, 32'h0000_00FF);
      chk("set_rdata", r_rd, 32'h0000_000F);
      chk("set_cycles", r_cyc, 3);

      slave_data = 32'h1234_5678; lat_rd = 2; lat_wr = 3;
      run_txn(0, 0, 0, 1, 12'h301, 32'hFFFF_0000);
      chk("clr_wdata", r_wd, 32'h0000_5678);
      chk("clr_nrd", r_nrd, 3);
      chk("clr_nwr", r_nwr, 4);
      run_txn(1, 1, 0, 1, 12'h302, 32'hFFFF_0000);
      chk("wrclr_wdata", r_wd, 32'hFFFF_0000);
      run_txn(0, 0, 1, 1, 12'h303, 32'h0000_FFFF);
      chk("setclr_wdata", r_wd, 32'h1234_FFFF);

      lat_rd = 0; lat_wr = 0;
      apply_reset();
      run_both(4);
      chk("rr_order", {order[0][0], order[1][0], order[2][0], order[3][0]}, 4'b0101);

      lat_rd = 255;
      run_txn(0, 0, 1, 0, 12'h400, 32'h1);
      chk("to_rd_nrd", r_nrd, 16);
      chk("to_rd_nwr", r_nwr, 0);
      chk("to_rd_err", {127'h0, r_err}, 128'h1);
      chk("to_rd_data", r_rd, 32'h0);
      chk("to_rd_cycles", r_cyc, 17);

      slave_data = 32'h0000_A5A5; lat_rd = 0; lat_wr = 255;
      run_txn(1, 1, 0, 0, 12'h401, 32'h1);
      chk("to_wr_err", {127'h0, r_err}, 128'h1);
      chk("to_wr_nwr", r_nwr, 16);
      chk("to_wr_rdata", r_rd, 32'h0000_A5A5);

      lat_rd = 15; lat_wr = 0;
      run_txn(0, 0, 0, 0, 12'h402, 32'h0);
      chk("edge_rd_err", {127'h0, r_err}, 128'h0);
      chk("edge_rd_nrd", r_nrd, 16);

      // Reset in the middle of a stalled write on port 0.
      lat_rd = 0; lat_wr = 255;
      @(negedge i_clk);
      i_m0_req = 1'b1; i_m0_wr = 1'b1; i_m0_set = 0; i_m0_clr = 0; i_m0_addr = 12'h500; i_m0_wr_data = 32'h77;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge i_clk);
         if (o_ext_wr) got = 1'b1;
      end
      chk("mid_wr_seen", {127'h0, got}, 128'h1);
      repeat (3) @(negedge i_clk);
      @(posedge i_clk);
      #2;
      i_rst = 1'b1;
      #1;
      chk("rst_drop", {o_ext_wr, o_busy, o_m0_ack, o_m1_ack}, 4'b0000);
      i_m0_req = 1'b0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      lat_wr = 0;
      run_both(1);
      chk("post_rst_grant", order[0], 0);

      repeat (3) @(negedge i_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
